// File: rtl/wave_player.sv
// wave_player: streams sample-RAM words, in address order, into the DAC FIFO and hides the RAM's one-cycle read latency.
// Define WAVE_PLAYER_LOOP_EN to honour the loop port (continuous wrap); otherwise every run is one-shot.
module wave_player #(
   parameter int ADDR_SIZE = 8,
   parameter int DATA_W    = 14
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 loop,
   input  logic [ADDR_SIZE:0]   num_samples,
   output logic [ADDR_SIZE-1:0] mem_addr,
   input  logic [DATA_W-1:0]    mem_dout,
   output logic [DATA_W-1:0]    fifo_din,
   output logic                 fifo_wr_en,
   input  logic                 fifo_almost_full,
   input  logic                 fifo_full,
   output logic                 busy,
   output logic                 done
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

   localparam logic [ADDR_SIZE:0] PTR_ONE = {{ADDR_SIZE{1'b0}}, 1'b1};

   state_e              state_q, state_d;
   logic [ADDR_SIZE:0]  n_lat_q, n_lat_d;
   logic [ADDR_SIZE:0]  rd_ptr_q, rd_ptr_d;
   logic                inflight_q, inflight_d;
   logic                skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0]   skid_data_q, skid_data_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                oneshot_q, oneshot_d;
   logic                done_q, done_d;
   logic                retire, issue, last_issue, drain_empty;

`ifndef WAVE_PLAYER_LOOP_EN
   logic unused_loop;
   assign unused_loop = loop;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         n_lat_q      <= '0;
         rd_ptr_q     <= '0;
         inflight_q   <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         oneshot_q    <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         n_lat_q      <= n_lat_d;
         rd_ptr_q     <= rd_ptr_d;
         inflight_q   <= inflight_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         oneshot_q    <= oneshot_d;
         done_q       <= done_d;
      end
   end

   assign retire = out_valid_q & ~fifo_full;

   // Output stage refills from skid first so FIFO order always matches read order.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (retire || !out_valid_q) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = inflight_q;
            if (inflight_q) skid_data_d = mem_dout;
         end else if (inflight_q) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_dout;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (inflight_q) begin
         skid_valid_d = 1'b1;
         skid_data_d  = mem_dout;
      end
   end

   // Issue only while next cycle's skid is free, so out+skid can always absorb the in-flight word.
   always_comb begin
      issue       = (state_q == RUN) & enable & ~fifo_almost_full & ~skid_valid_d;
      last_issue  = issue & (rd_ptr_q == n_lat_q - PTR_ONE);
      drain_empty = ~inflight_q & ~skid_valid_q & (~out_valid_q | retire);
      fifo_wr_en  = retire;
      fifo_din    = out_data_q;
      mem_addr    = rd_ptr_q[ADDR_SIZE-1:0];
      busy        = (state_q != IDLE);
      done        = done_q;
   end

   always_comb begin
      state_d    = state_q;
      n_lat_d    = n_lat_q;
      rd_ptr_d   = rd_ptr_q;
      oneshot_d  = oneshot_q;
      done_d     = 1'b0;
      inflight_d = issue;
      case (state_q)
         IDLE: begin
            if (enable && num_samples != '0) begin
               n_lat_d   = num_samples;
               rd_ptr_d  = '0;
               oneshot_d = 1'b0;
               state_d   = RUN;
            end
         end
         RUN: begin
            if (issue) rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (!enable) begin
               state_d = DRAIN;
            end else if (last_issue) begin
`ifdef WAVE_PLAYER_LOOP_EN
               if (loop) begin
                  rd_ptr_d = '0;
               end else begin
                  state_d   = DRAIN;
                  oneshot_d = 1'b1;
               end
`else
               state_d   = DRAIN;
               oneshot_d = 1'b1;
`endif
            end
         end
         DRAIN: begin
            if (drain_empty) begin
               state_d = IDLE;
               done_d  = oneshot_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_wave_player.sv
// tb_wave_player: randomized playback runs against a queue-based model of the
// expected FIFO stream (word i == ram[i mod n]) plus spec timing points.
module tb_wave_player;
   logic        clk = 1'b0;
   logic        rst, enable, loop;
   logic [8:0]  num_samples;
   logic [7:0]  mem_addr;
   logic [13:0] mem_dout;
   logic [13:0] fifo_din;
   logic        fifo_wr_en, fifo_almost_full, fifo_full, busy, done;

   logic [13:0] ram [0:255];
   int          cyc;
   int          n_chk = 0, n_err = 0;

   logic [13:0] wq[$];
   int          wcyc[$];
   int          done_cnt = 0, done_cyc = -1, busy_cnt = 0, addr_chg = 0, full_viol = 0;
   logic [7:0]  prev_addr = 8'd0;

   wave_player #(.ADDR_SIZE(8), .DATA_W(14)) dut (
      .clk(clk), .rst(rst), .enable(enable), .loop(loop), .num_samples(num_samples),
      .mem_addr(mem_addr), .mem_dout(mem_dout), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
      .fifo_almost_full(fifo_almost_full), .fifo_full(fifo_full), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) mem_dout <= ram[mem_addr];

   always @(negedge clk) begin
      if (fifo_wr_en) begin
         wq.push_back(fifo_din);
         wcyc.push_back(cyc);
         if (fifo_full) full_viol++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (busy) busy_cnt++;
      if (mem_addr != prev_addr) addr_chg++;
      prev_addr = mem_addr;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic fill_ram(input bit ramp);
      for (int i = 0; i < 256; i++)
         ram[8'(i)] = ramp ? 14'(16'h100 + i) : 14'($urandom);
   endtask

   // Model: the k-th word written since base must be ram[k mod n].
   task automatic check_stream(input string tag, input int base, input int cnt, input int n);
      for (int k = 0; k < cnt; k++) begin
         if (base + k >= wq.size()) begin
            chk({tag, "_missing"}, 32'(wq.size()), 32'(base + cnt));
            return;
         end
         chk(tag, 32'(wq[base + k]), 32'(ram[8'(k % n)]));
      end
   endtask

   // One start request held until done (bounded), optional random backpressure.
   task automatic play(input int n, input bit lp, input bit rnd_af, input bit rnd_full,
                       input int full_from, input int full_len,
                       output bit busy_c1, output int max_a);
      num_samples = 9'(n);
      loop        = lp;
      cyc         = 0;
      enable      = 1'b1;
      busy_c1     = 1'b0;
      max_a       = 0;
      for (int t = 0; t < 3000; t++) begin
         tick();
         if (cyc == 1) busy_c1 = busy;
         if (busy && int'(mem_addr) > max_a) max_a = int'(mem_addr);
         if (done) break;
         fifo_almost_full = rnd_af ? 1'($urandom_range(0, 1)) : 1'b0;
         fifo_full = (cyc >= full_from && cyc < full_from + full_len) ||
                     (rnd_full && $urandom_range(0, 3) == 0);
      end
      chk("play_done", 32'(done), 32'd1);
      chk("busy_at_done", 32'(busy), 32'd0);
      enable           = 1'b0;
      fifo_almost_full = 1'b0;
      fifo_full        = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; loop = 1'b0; num_samples = '0;
      fifo_almost_full = 1'b0; fifo_full = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      int w0, d0, b0, a0, fv0, mx, wb;
      bit b1;
      fill_ram(1'b1);
      do_reset();

      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_fifo_din", 32'(fifo_din), 32'd0);
      chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);

      // Basic one-shot timing: writes in cycles 3..6, done/busy-low in cycle 7.
      w0 = wq.size(); d0 = done_cnt;
      play(4, 1'b0, 1'b0, 1'b0, 0, 0, b1, mx);
      chk("t1_busy_c1", 32'(b1), 32'd1);
      repeat (3) tick();
      chk("t1_nwr", 32'(wq.size() - w0), 32'd4);
      check_stream("t1_data", w0, 4, 4);
      for (int k = 0; k < 4 && w0 + k < wcyc.size(); k++)
         chk("t1_wr_cyc", 32'(wcyc[w0 + k]), 32'(3 + k));
      chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("t1_done_cyc", 32'(done_cyc), 32'd7);

      // Loop playback, then enable drop.
      fill_ram(1'b0);
      w0 = wq.size(); d0 = done_cnt;
`ifdef WAVE_PLAYER_LOOP_EN
      num_samples = 9'd3; loop = 1'b1; cyc = 0; enable = 1'b1;
      for (int t = 0; t < 200 && wq.size() - w0 < 12; t++) tick();
      enable = 1'b0;
      wb = wq.size();
      for (int t = 0; t < 50 && busy; t++) tick();
      repeat (2) tick();
      chk("t2_idle", 32'(busy), 32'd0);
      chk("t2_got12", 32'(wb - w0 >= 12), 32'd1);
      chk("t2_extra_le2", 32'(wq.size() - wb <= 2), 32'd1);
      chk("t2_no_done", 32'(done_cnt - d0), 32'd0);
      check_stream("t2_data", w0, wq.size() - w0, 3);
`else
      play(3, 1'b1, 1'b0, 1'b0, 0, 0, b1, mx);
      repeat (3) tick();
      chk("t2_nwr", 32'(wq.size() - w0), 32'd3);
      chk("t2_done_cnt", 32'(done_cnt - d0), 32'd1);
      check_stream("t2_data", w0, 3, 3);
`endif

      // Random almost_full, a 5-cycle fifo_full window mid-run.
      fill_ram(1'b0);
      w0 = wq.size(); d0 = done_cnt; fv0 = full_viol;
      play(8, 1'b0, 1'b1, 1'b0, 6, 5, b1, mx);
      repeat (3) tick();
      chk("t3_nwr", 32'(wq.size() - w0), 32'd8);
      check_stream("t3_data", w0, 8, 8);
      chk("t3_full_viol", 32'(full_viol - fv0), 32'd0);
      chk("t3_done_cnt", 32'(done_cnt - d0), 32'd1);

      // Full-depth run.
      fill_ram(1'b0);
      w0 = wq.size(); d0 = done_cnt;
      play(256, 1'b0, 1'b0, 1'b0, 0, 0, b1, mx);
      repeat (3) tick();
      chk("t4_nwr", 32'(wq.size() - w0), 32'd256);
      check_stream("t4_data", w0, 256, 256);
      chk("t4_max_addr", 32'(mx), 32'hFF);
      chk("t4_done_cnt", 32'(done_cnt - d0), 32'd1);

      // num_samples = 0 must never start.
      w0 = wq.size(); b0 = busy_cnt; a0 = addr_chg;
      num_samples = 9'd0; enable = 1'b1;
      repeat (10) tick();
      enable = 1'b0;
      tick();
      chk("t5_busy", 32'(busy_cnt - b0), 32'd0);
      chk("t5_addr_chg", 32'(addr_chg - a0), 32'd0);
      chk("t5_nwr", 32'(wq.size() - w0), 32'd0);

      // Reset mid-run with output and skid both holding words.
      fill_ram(1'b0);
      num_samples = 9'd10; loop = 1'b0; fifo_full = 1'b1; cyc = 0; enable = 1'b1;
      repeat (4) tick();
      rst = 1'b1; fifo_full = 1'b0; enable = 1'b0;
      tick();
      chk("t6_mem_addr", 32'(mem_addr), 32'd0);
      chk("t6_fifo_din", 32'(fifo_din), 32'd0);
      chk("t6_wr_en", 32'(fifo_wr_en), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_done", 32'(done), 32'd0);
      rst = 1'b0;
      tick();
      w0 = wq.size(); d0 = done_cnt;
      play(5, 1'b0, 1'b0, 1'b0, 0, 0, b1, mx);
      repeat (3) tick();
      chk("t6_nwr", 32'(wq.size() - w0), 32'd5);
      check_stream("t6_data", w0, 5, 5);
      chk("t6_done_cnt", 32'(done_cnt - d0), 32'd1);

      // Random lengths under random almost_full and full.
      for (int it = 0; it < 6; it++) begin
         int n;
         n = $urandom_range(1, 40);
         fill_ram(1'b0);
         w0 = wq.size(); d0 = done_cnt; fv0 = full_viol;
         play(n, 1'b0, 1'b1, 1'b1, 0, 0, b1, mx);
         repeat (3) tick();
         chk("t7_nwr", 32'(wq.size() - w0), 32'(n));
         check_stream("t7_data", w0, n, n);
         chk("t7_full_viol", 32'(full_viol - fv0), 32'd0);
         chk("t7_done_cnt", 32'(done_cnt - d0), 32'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
